// File: rtl/coco_serial_pkg.sv
// Shared constants and types for the CoCo bit-banged serial receiver.
package coco_serial_pkg;

  // 600 baud at 57.272 MHz, oversampled 16x
  localparam int DEFAULT_TICK_DIV = 5966;
  localparam int TICKS_PER_BIT    = 16;
  localparam int HALF_BIT_TICKS   = TICKS_PER_BIT / 2;

  // FIFO occupancy output width (covers 0..16)
  localparam int LEVEL_W = 5;

  // Deserializer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Pointer width for a power-of-two FIFO depth (at least one bit)
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/coco_rx_fifo.sv
// Byte FIFO for the serial receiver. The head entry is held in an output
// register so the storage array can map onto block/distributed RAM with a
// registered read, while still showing a pushed byte on the following clk.
module coco_rx_fifo
  import coco_serial_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [7:0]         i_wdata,
  input  logic               i_pop,
  output logic [7:0]         o_rdata,
  output logic               o_full,
  output logic               o_empty,
  output logic [LEVEL_W-1:0] o_level
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [LEVEL_W-1:0] LVL_DEPTH = LEVEL_W'(DEPTH);

  logic [7:0]         r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic [7:0]         r_rdata;

  logic               w_do_push;
  logic               w_do_pop;
  logic [PW-1:0]      w_wr_ptr_next;
  logic [PW-1:0]      w_rd_ptr_next;
  logic [LEVEL_W-1:0] w_level_after_pop;
  logic [LEVEL_W-1:0] w_level_next;
  logic [7:0]         w_head_next;

  assign o_full  = (r_level == LVL_DEPTH);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_rdata;

  // Qualify push/pop, advance pointers, and work out what the head will be
  always_comb begin
    w_do_pop          = i_pop & ~o_empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same clk
    w_do_push         = i_push & (~o_full | w_do_pop);
    w_wr_ptr_next     = w_do_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
    w_rd_ptr_next     = w_do_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;
    w_level_after_pop = r_level - LEVEL_W'(w_do_pop);
    w_level_next      = w_level_after_pop + LEVEL_W'(w_do_push);
    if (w_level_next == '0) begin
      w_head_next = 8'h00;
    end else if (w_level_after_pop == '0) begin
      // FIFO was (or became) empty: the incoming byte is the new head
      w_head_next = i_wdata;
    end else begin
      // Head entry is already stored (never the slot written this clk)
      w_head_next = r_mem[w_rd_ptr_next];
    end
  end

  // Storage array: write-only port, no reset so it can infer RAM
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, occupancy and registered head output
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_rdata  <= 8'h00;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_level  <= w_level_next;
      r_rdata  <= w_head_next;
    end
  end

endmodule

// File: rtl/coco_serial_rx.sv
// 8N1 serial receiver for the CoCo bit-banger line: 16x oversampling
// deserializer with start-bit glitch rejection, framing/break handling,
// and a small byte FIFO toward a valid/ready consumer.
module coco_serial_rx
  import coco_serial_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int DEPTH    = 4,
  parameter bit INVERT   = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rxd,
  output logic [7:0]         o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_framing_err,
  output logic               o_overrun,
  output logic [LEVEL_W-1:0] o_level
);

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  MID_LAST = 4'(HALF_BIT_TICKS - 1);
  localparam logic [3:0]  BIT_LAST = 4'(TICKS_PER_BIT - 1);

  logic       w_rxd_in;
  logic       w_line;
  logic       w_tick;
  logic       w_push;
  logic       w_pop;
  logic       w_ferr_next;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_sync_live;

  rx_state_e  r_state;
  rx_state_e  w_state_next;
  logic [15:0] r_div;
  logic [15:0] w_div_next;
  logic [3:0] r_tick_cnt;
  logic [3:0] w_tick_cnt_next;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_idx_next;
  logic [7:0] r_shift;
  logic [7:0] w_shift_next;

  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_fill;
  logic       r_armed;
  logic       r_framing_err;
  logic       r_overrun;

  // Optional line inversion ahead of the synchronizer
  if (INVERT) begin : g_invert
    assign w_rxd_in = ~i_rxd;
  end else begin : g_direct
    assign w_rxd_in = i_rxd;
  end

  // Two-flop synchronizer; resets to mark so reset looks like an idle line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= w_rxd_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line      = r_sync2;
  assign w_sync_live = (r_fill == 2'd2);

  // Arm start detection only after a real mark has been seen since reset,
  // so a line that is low at reset release (mid-frame) is not taken as a
  // falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill  <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      if (!w_sync_live) begin
        r_fill <= r_fill + 2'd1;
      end
      if (w_sync_live && w_line) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_tick = (r_div == DIV_LAST);

  // Next-state, counters, shift register, push and framing-error decode
  always_comb begin
    w_state_next    = r_state;
    w_div_next      = w_tick ? 16'd0 : r_div + 16'd1;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_push          = 1'b0;
    w_ferr_next     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !w_line) begin
          w_state_next    = ST_START;
          w_div_next      = 16'd0;
          w_tick_cnt_next = 4'd0;
          w_bit_idx_next  = 3'd0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_tick_cnt == MID_LAST) begin
            // Mid start bit: still low is a real start, high was a glitch
            w_tick_cnt_next = 4'd0;
            w_state_next    = w_line ? ST_IDLE : ST_DATA;
          end else begin
            w_tick_cnt_next = r_tick_cnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_tick_cnt == BIT_LAST) begin
            w_tick_cnt_next = 4'd0;
            w_shift_next    = {w_line, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              w_state_next = ST_STOP;
            end else begin
              w_bit_idx_next = r_bit_idx + 3'd1;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_tick_cnt == BIT_LAST) begin
            w_tick_cnt_next = 4'd0;
            if (w_line) begin
              w_push       = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_ferr_next  = 1'b1;
              w_state_next = ST_BREAK;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 4'd1;
          end
        end
      end
      ST_BREAK: begin
        if (w_line) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Deserializer state register and datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_div      <= 16'd0;
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      r_state    <= w_state_next;
      r_div      <= w_div_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
    end
  end

  assign w_pop = ~w_fifo_empty & i_ready;

  // Status pulses: framing error, and a completed byte lost to a full FIFO
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_framing_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_framing_err <= w_ferr_next;
      r_overrun     <= w_push & w_fifo_full & ~w_pop;
    end
  end

  coco_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (w_pop),
    .o_rdata (o_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (o_level)
  );

  assign o_valid       = ~w_fifo_empty;
  assign o_framing_err = r_framing_err;
  assign o_overrun     = r_overrun;

endmodule

// File: doc/coco_serial_rx.md
COCO_SERIAL_RX -- requirements
Module: coco_serial_rx

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5966, meaning clk cycles per 1/16 bit (600 baud at 57.272 MHz); legal range 2..65535.
REQ-002 SHALL have parameter DEPTH, default 4, meaning byte FIFO depth; power of two, 2..16.
REQ-003 SHALL have parameter INVERT, default 0; when 1, rxd is inverted before use.
REQ-004 clk  in  1  system clock, 57.272 MHz.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 rxd  in  1  bit-banged RS-232 line from PIA1 PA1 (rsout1); idle/mark = 1 after INVERT.
REQ-007 data  out  8  received byte at FIFO head.
REQ-008 valid  out  1  FIFO non-empty; data is meaningful.
REQ-009 ready  in  1  consumer accepts data when valid&ready at a clk edge.
REQ-010 framing_err  out  1  one-cycle pulse: stop bit sampled 0.
REQ-011 overrun  out  1  one-cycle pulse: completed byte dropped because FIFO full.
REQ-012 level  out  5  current FIFO occupancy, 0..DEPTH.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer (both flops reset to 1) before any use; latency 2 clk.
REQ-014 SHALL generate a one-clk tick every TICK_DIV clk; the tick counter SHALL restart at 0 on IDLE->START.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: synced line 0 -> START, tick-count-in-bit and bit index cleared.
REQ-017 START: on 8th tick, line 0 -> DATA; line 1 -> IDLE (glitch rejected, nothing pushed).
REQ-018 DATA: sample on every 16th tick after start-bit midpoint; shift in LSB first; after bit 7 -> STOP.
REQ-019 STOP: 16 ticks after bit-7 sample, line 1 -> push byte, -> IDLE; line 0 -> framing_err pulse, byte discarded, -> BREAK.
REQ-020 BREAK: remain until synced line is 1, then -> IDLE.
REQ-021 Push SHALL make valid/data visible the clk after the stop sample.
REQ-022 Pop SHALL occur on valid&ready; next entry (or valid=0) visible the following clk.
REQ-023 Push when level==DEPTH and no pop in same clk: byte dropped, overrun pulse, FIFO unchanged.
REQ-024 Push and pop in same clk when full: both performed, level stays DEPTH, no overrun.
REQ-025 Push and pop in same clk when empty is impossible (valid=0); level becomes 1.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow.
REQ-027 data SHALL hold its value while valid=1 and ready=0.

Reset
REQ-028 reset low SHALL asynchronously force: state IDLE, counters 0, shift register 0, FIFO empty, valid=0, data=0, level=0, framing_err=0, overrun=0, synchronizer=1.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte; after release, reception starts only on a new falling edge.

Structure
REQ-030 State enum, DEFAULT_TICK_DIV (5966) and ticks-per-bit constant (16) SHALL reside in shared package coco_serial_pkg.
REQ-031 FIFO SHALL be a separate sub-module coco_rx_fifo (push, pop, full, empty, level); deserializer FSM in coco_serial_rx.

Verification (TICK_DIV=4, 64 clk/bit, DEPTH=4)
REQ-032 Send 0x55 (8N1), ready=1 -> valid one cycle with data=0x55, framing_err=0, level returns 0.
REQ-033 Low pulse of 20 clk on idle line -> START rejects, no valid, state IDLE.
REQ-034 Send 0xA3 with stop bit 0 -> framing_err pulse, no push; line held 0 for 300 clk then 1 -> next byte 0x0F received correctly.
REQ-035 ready=0, send 0x01..0x05 -> level=4, overrun pulse on 5th byte; then pop yields 0x01,0x02,0x03,0x04 in order.
REQ-036 Full FIFO, ready pulsed in the exact clk of 5th push -> no overrun, level 4, contents 0x02..0x05.
REQ-037 reset asserted during bit 3 of 0xC6, released, then 0x3C sent -> only 0x3C delivered; INVERT=1 run of REQ-032 with inverted line yields 0x55.
